// File: rtl/encoder_4_2_pending_pkg.sv
// Shared types and helpers for the 4-to-2 pending priority encoder and its
// companion 2-to-4 decoder.
package enc_pkg;

    localparam int ENC_N = 4;
    localparam int ENC_W = $clog2(ENC_N);

    typedef enum logic {IDLE, PRESENT} enc_state_t;

    // Index of the highest set bit; returns 0 for an all-zero vector.
    function automatic logic [ENC_W-1:0] msb_index(logic [ENC_N-1:0] v);
        logic [ENC_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ENC_N; i++) begin
            if (v[i]) idx = ENC_W'(i);
        end
        return idx;
    endfunction

    function automatic logic [ENC_N-1:0] onehot(logic [ENC_W-1:0] idx);
        return ENC_N'(1) << idx;
    endfunction

endpackage

// File: rtl/encoder_4_2_pending_if.sv
// Request capture and index output bundle of the pending priority encoder.
interface encoder_4_2_pending_if #(parameter int N = 4);
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;
    logic [N-1:0] pend;
    logic         err_dup;

    // Output handshake: an index transfers on a rising edge where out_valid
    // and out_ready are both high; out_idx is held stable until that edge.
    modport master (
        output en, req, out_ready,
        input  out_valid, out_idx, pend, err_dup
    );

    modport slave (
        input  en, req, out_ready,
        output out_valid, out_idx, pend, err_dup
    );
endinterface

// File: rtl/encoder_4_2_pending_prio_sel.sv
// Combinational highest-set-bit encoder: N request bits in, W-bit index plus
// an any-bit-set flag out.
module prio_sel
    import enc_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] idx,
    output logic         any
);

    assign any = |v;

    generate
        if (N == ENC_N) begin : g_pkg
            assign idx = msb_index(v);
        end else begin : g_loop
            always_comb begin
                idx = '0;
                for (int i = 0; i < N; i++) begin
                    if (v[i]) idx = W'(i);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/encoder_4_2_pending.sv
// Captures request pulses into a pending set and streams their indices out one
// at a time, highest index first, flagging requests that are already pending.
module encoder_4_2_pending
    import enc_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    encoder_4_2_pending_if.slave   bus,
    output enc_state_t             dbg_state
);

    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = N'(1);

    enc_state_t   state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         dup_q, dup_d;

    logic [N-1:0] cap, avail, present_oh, sel_oh;
    logic [W-1:0] sel_idx;
    logic         sel_any;
    logic         hs;

    assign cap        = bus.req & {N{bus.en}};
    assign avail      = pend_q | cap;
    assign present_oh = valid_q ? (ONE << idx_q) : '0;
    assign hs         = valid_q & bus.out_ready;
    assign sel_oh     = ONE << sel_idx;

    prio_sel #(.N(N)) u_prio_sel (
        .v   (avail),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        // The index retiring this cycle may be re-requested without a flag.
        dup_d   = |(cap & (pend_q | (hs ? '0 : present_oh)));
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    pend_d  = avail & ~sel_oh;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (hs) begin
                    if (sel_any) begin
                        idx_d  = sel_idx;
                        pend_d = avail & ~sel_oh;
                    end else begin
                        valid_d = 1'b0;
                        pend_d  = '0;
                        state_d = IDLE;
                    end
                end else begin
                    pend_d = avail;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            dup_q   <= dup_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.pend      = pend_q;
    assign bus.err_dup   = dup_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_encoder_4_2_pending.sv
// Directed bench for encoder_4_2_pending: a monitor pops expected indices on
// every accepted transfer; status outputs are checked inline.
module tb_encoder_4_2_pending;
    import enc_pkg::*;

    logic       clk;
    logic       rst_n;
    enc_state_t dbg_state;
    int         tests;
    int         fails;
    logic [1:0] exp_q[$];

    encoder_4_2_pending_if #(.N(4)) bus ();

    encoder_4_2_pending #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: one pop per accepted index
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_idx: got %0d expected none", bus.out_idx);
            end else begin
                check("idx_order", 32'(bus.out_idx), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.en = 1'b1;
        bus.req = 4'b1111;
        bus.out_ready = 1'b0;

        // reset holds everything idle despite requests
        step();
        step();
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_pend", 32'(bus.pend), 0);
        check("rst_dup", 32'(bus.err_dup), 0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        bus.req = 4'b0000;
        step();
        step();
        check("post_rst_valid", 32'(bus.out_valid), 0);
        check("post_rst_pend", 32'(bus.pend), 0);

        // single request
        bus.req = 4'b0100;
        bus.out_ready = 1'b1;
        exp_q.push_back(2'd2);
        step();
        bus.req = 4'b0000;
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_idx", 32'(bus.out_idx), 2);
        check("single_pend", 32'(bus.pend), 0);
        step();
        check("single_done_valid", 32'(bus.out_valid), 0);
        check("single_done_pend", 32'(bus.pend), 0);

        // priority drain 3,1,0
        bus.req = 4'b1011;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        step();
        bus.req = 4'b0000;
        check("drain_pend0", 32'(bus.pend), 32'b0011);
        step();
        check("drain_pend1", 32'(bus.pend), 32'b0001);
        step();
        check("drain_pend2", 32'(bus.pend), 0);
        step();
        check("drain_done", 32'(bus.out_valid), 0);

        // back-pressure
        bus.out_ready = 1'b0;
        bus.req = 4'b0011;
        exp_q.push_back(2'd1);
        step();
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_idx", 32'(bus.out_idx), 1);
            check("bp_pend", 32'(bus.pend), 32'b0001);
            step();
        end

        // duplicate of the stalled index
        bus.req = 4'b0010;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        step();
        bus.req = 4'b0000;
        check("dup_pulse", 32'(bus.err_dup), 1);
        check("dup_pend", 32'(bus.pend), 32'b0011);
        check("dup_idx", 32'(bus.out_idx), 1);
        step();
        check("dup_clear", 32'(bus.err_dup), 0);

        // late higher-priority request overtakes pending bits
        bus.req = 4'b1000;
        bus.out_ready = 1'b1;
        step();
        bus.req = 4'b0000;
        check("late_idx", 32'(bus.out_idx), 3);
        check("late_dup", 32'(bus.err_dup), 0);
        check("late_pend", 32'(bus.pend), 32'b0011);
        step();
        step();
        step();
        check("late_done", 32'(bus.out_valid), 0);
        bus.out_ready = 1'b0;
        step();

        // re-request of the index accepted in the same cycle
        bus.out_ready = 1'b1;
        bus.req = 4'b0100;
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        step();
        step();
        bus.req = 4'b0000;
        check("reaccept_dup", 32'(bus.err_dup), 0);
        check("reaccept_valid", 32'(bus.out_valid), 1);
        check("reaccept_idx", 32'(bus.out_idx), 2);
        step();
        check("reaccept_done", 32'(bus.out_valid), 0);

        // capture disabled
        bus.en = 1'b0;
        bus.req = 4'b1111;
        step();
        check("en0_valid", 32'(bus.out_valid), 0);
        check("en0_dup", 32'(bus.err_dup), 0);
        step();
        check("en0_pend", 32'(bus.pend), 0);
        check("en0_valid2", 32'(bus.out_valid), 0);

        // reset during presentation discards everything
        bus.en = 1'b1;
        bus.req = 4'b0110;
        bus.out_ready = 1'b0;
        step();
        bus.req = 4'b0000;
        check("mid_idx", 32'(bus.out_idx), 2);
        check("mid_pend", 32'(bus.pend), 32'b0010);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_pend", 32'(bus.pend), 0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_rst_valid", 32'(bus.out_valid), 0);
        end

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
